request_unit: RTL and testbench

- Sequencing end for the control unit's memory-request outputs (dread, dwrite, halt).
- Converts per-instruction decode into registered instruction/data memory enables toward the memory arbiter, and generates the PC advance enable.
- Latches halt stickily.
- Keeps saturating retired-instruction and data-stall counters for the datapath and bench.

---
 rtl/cpu_types_pkg.sv | 12 +
 rtl/sat_counter.sv | 19 +
 rtl/request_unit.sv | 105 ++++++++++
 tb/tb_request_unit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared control-path types and constants
package cpu_types_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } ru_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/request_unit.sv
// rtl/request_unit.sv - memory request sequencing, halt latch and retire/stall counters
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dread,
    input  logic             dwrite,
    input  logic             halt,
    output logic             iREN,
    output logic             dREN,
    output logic             dWEN,
    output logic             pc_en,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    ru_state_t state;
    logic      fetch_retire;
    logic      data_retire;
    logic      stall_inc;

    // An instruction retires either straight out of FETCH (no memory access)
    // or when its data access completes.
    assign fetch_retire = (state == FETCH) && ihit && !halt && !dread && !dwrite;
    assign data_retire  = (state == DATA) && dhit;

    // Gated with nRST so the PC cannot advance while reset is held.
    assign pc_en     = nRST && (fetch_retire || data_retire);
    assign stall_inc = (state == DATA) && !dhit;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= FETCH;
            iREN   <= 1'b1;
            dREN   <= 1'b0;
            dWEN   <= 1'b0;
            halted <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (ihit) begin
                        // Halt outranks any data request on the same instruction.
                        if (halt) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                            iREN   <= 1'b0;
                        end else if (dread || dwrite) begin
                            state <= DATA;
                            iREN  <= 1'b0;
                            // Store wins when decode flags both; flag it.
                            dREN  <= dread & ~dwrite;
                            dWEN  <= dwrite;
                            if (dread && dwrite) begin
                                err <= 1'b1;
                            end
                        end
                    end
                end
                DATA: begin
                    if (dhit) begin
                        state <= FETCH;
                        iREN  <= 1'b1;
                        dREN  <= 1'b0;
                        dWEN  <= 1'b0;
                    end
                end
                HALTED: begin
                    iREN   <= 1'b0;
                    dREN   <= 1'b0;
                    dWEN   <= 1'b0;
                    halted <= 1'b1;
                end
                default: begin
                    state <= FETCH;
                    iREN  <= 1'b1;
                    dREN  <= 1'b0;
                    dWEN  <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (pc_en),
        .cnt  (instr_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (stall_inc),
        .cnt  (stall_cnt)
    );

endmodule

// File: tb/tb_request_unit.sv
// tb/tb_request_unit.sv - scoreboard bench for request_unit
module tb_request_unit;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic         ihit = 1'b0;
    logic         dhit = 1'b0;
    logic         dread = 1'b0;
    logic         dwrite = 1'b0;
    logic         halt = 1'b0;
    logic         iREN, dREN, dWEN, pc_en, halted, err;
    logic [W-1:0] instr_cnt, stall_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string nm;
        logic  iren, dren, dwen, pc, hlt, er;
        int    ic, sc;
    } exp_t;

    exp_t sb[$];

    request_unit #(.CNT_W(W)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .ihit      (ihit),
        .dhit      (dhit),
        .dread     (dread),
        .dwrite    (dwrite),
        .halt      (halt),
        .iREN      (iREN),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .pc_en     (pc_en),
        .halted    (halted),
        .err       (err),
        .instr_cnt (instr_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic void chk(input string nm, input string f, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s.%s got=%0d want=%0d", nm, f, got, want);
        end
    endfunction

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.nm, "iREN",      int'(iREN),      int'(e.iren));
                chk(e.nm, "dREN",      int'(dREN),      int'(e.dren));
                chk(e.nm, "dWEN",      int'(dWEN),      int'(e.dwen));
                chk(e.nm, "pc_en",     int'(pc_en),     int'(e.pc));
                chk(e.nm, "halted",    int'(halted),    int'(e.hlt));
                chk(e.nm, "err",       int'(err),       int'(e.er));
                chk(e.nm, "instr_cnt", int'(instr_cnt), e.ic);
                chk(e.nm, "stall_cnt", int'(stall_cnt), e.sc);
            end
        end
    end

    // inp = {ihit, dhit, dread, dwrite, halt}; e = {iREN, dREN, dWEN, pc_en, halted, err}
    task automatic cyc(input string nm, input logic rst, input logic [4:0] inp,
                       input logic [5:0] e, input int ic, input int sc);
        exp_t x;
        @(posedge CLK);
        #1;
        nRST = rst;
        {ihit, dhit, dread, dwrite, halt} = inp;
        x.nm = nm;
        {x.iren, x.dren, x.dwen, x.pc, x.hlt, x.er} = e;
        x.ic = ic;
        x.sc = sc;
        sb.push_back(x);
    endtask

    initial begin
        int budget;
        // reset held with ihit high: pc_en must stay low
        cyc("rst",    1'b0, 5'b10000, 6'b100000, 0, 0);

        // three ALU instructions then idle
        cyc("alu0",   1'b1, 5'b10000, 6'b100100, 0, 0);
        cyc("alu1",   1'b1, 5'b10000, 6'b100100, 1, 0);
        cyc("alu2",   1'b1, 5'b10000, 6'b100100, 2, 0);
        cyc("idle0",  1'b1, 5'b00000, 6'b100000, 3, 0);

        // load with four stall cycles; ihit during DATA ignored
        cyc("ld",     1'b1, 5'b10100, 6'b100000, 3, 0);
        cyc("ldw0",   1'b1, 5'b00000, 6'b010000, 3, 0);
        cyc("ldw1",   1'b1, 5'b10000, 6'b010000, 3, 1);
        cyc("ldw2",   1'b1, 5'b00000, 6'b010000, 3, 2);
        cyc("ldw3",   1'b1, 5'b00000, 6'b010000, 3, 3);
        cyc("ldhit",  1'b1, 5'b01000, 6'b010100, 3, 4);
        cyc("ldpost", 1'b1, 5'b00000, 6'b100000, 4, 4);

        // load+store flags together: store wins, err latched
        cyc("st",     1'b1, 5'b10110, 6'b100000, 4, 4);
        cyc("sthit",  1'b1, 5'b01000, 6'b001101, 4, 4);
        cyc("stpost", 1'b1, 5'b01000, 6'b100001, 5, 4); // dhit in FETCH ignored

        // async reset in the middle of a data wait
        cyc("ld2",    1'b1, 5'b10100, 6'b100001, 5, 4);
        cyc("ld2w",   1'b1, 5'b00000, 6'b010001, 5, 4);
        cyc("arst",   1'b0, 5'b10000, 6'b100000, 0, 0);
        cyc("resume", 1'b1, 5'b10000, 6'b100100, 0, 0);
        cyc("idle1",  1'b1, 5'b00000, 6'b100000, 1, 0);

        // halt outranks a store; afterwards everything is ignored
        cyc("halt",   1'b1, 5'b10011, 6'b100000, 1, 0);
        cyc("hld0",   1'b1, 5'b11100, 6'b000010, 1, 0);
        cyc("hld1",   1'b1, 5'b01010, 6'b000010, 1, 0);
        cyc("hld2",   1'b1, 5'b00000, 6'b000010, 1, 0);

        // saturation of the 4-bit retire counter
        cyc("rst2",   1'b0, 5'b00000, 6'b100000, 0, 0);
        for (int k = 0; k < 22; k++) begin
            cyc($sformatf("sat%0d", k), 1'b1, 5'b10000, 6'b100100, (k < 15) ? k : 15, 0);
        end
        cyc("satend", 1'b1, 5'b00000, 6'b100000, 15, 0);

        budget = 10;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge CLK);
            budget--;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d pending want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
